icache_flush_sequencer: RTL and testbench

ICACHE_FLUSH_SEQUENCER -- requirements
Module: icache_flush_sequencer

---
 rtl/icache_flush_sequencer_pkg.sv | 9 +
 rtl/icache_flush_sequencer.sv | 91 +++++++++
 tb/tb_icache_flush_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_flush_sequencer_pkg.sv
// icache_flush_sequencer_pkg: L1I geometry, tag/index types and flush FSM state encoding.
package icache_flush_sequencer_pkg;
    localparam int L1I_SETS  = 64;
    localparam int L1I_WAYS  = 4;
    localparam int L1I_TAG_W = 20;
    typedef logic [$clog2(L1I_SETS)-1:0] l1i_set_idx_t;
    typedef logic [L1I_TAG_W-1:0]        l1i_tag_t;
    typedef enum logic [1:0] {IDLE, DRAIN, WALK, DONE} flush_state_t;
endpackage

// File: rtl/icache_flush_sequencer.sv
// icache_flush_sequencer: stalls fetch, then walks the L1I sets invalidating every way; fills always win the tag port.
// Define ICACHE_FLUSH_RANGE_EN to add flush_start_set/flush_end_set, which restrict the walk to an inclusive set range.
module icache_flush_sequencer
    import icache_flush_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush_req,
`ifdef ICACHE_FLUSH_RANGE_EN
    input  l1i_set_idx_t        flush_start_set,
    input  l1i_set_idx_t        flush_end_set,
`endif
    output logic                flush_ack,
    output logic                flush_busy,
    output logic                flush_done,
    output logic                fetch_stall,
    input  logic [L1I_WAYS-1:0] l2_itag_update_en,
    input  l1i_set_idx_t        l2_itag_update_set,
    input  l1i_tag_t            l2_itag_update_tag,
    input  logic                l2_itag_update_valid,
    output logic [L1I_WAYS-1:0] itag_update_en,
    output l1i_set_idx_t        itag_update_set,
    output l1i_tag_t            itag_update_tag,
    output logic                itag_update_valid
);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);

    flush_state_t  state, state_nxt;
    logic [DW-1:0] drain_cnt;
    l1i_set_idx_t  set_cnt, end_set, start_set, last_set;
    logic          fill, walk_inv, walk_last;

`ifdef ICACHE_FLUSH_RANGE_EN
    // An inverted range collapses to the single start set.
    assign start_set = flush_start_set;
    assign last_set  = flush_start_set > flush_end_set ? flush_start_set : flush_end_set;
`else
    assign start_set = '0;
    assign last_set  = l1i_set_idx_t'(L1I_SETS - 1);
`endif

    assign fill      = |l2_itag_update_en;
    assign walk_inv  = state == WALK && !fill;
    assign walk_last = set_cnt == end_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = flush_req ? DRAIN : IDLE;
            DRAIN:   state_nxt = drain_cnt == DRAIN_LAST ? WALK : DRAIN;
            WALK:    state_nxt = walk_inv && walk_last ? DONE : WALK;
            default: state_nxt = IDLE;
        endcase
    end

    // The walker only advances on cycles where it actually owned the tag port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt <= '0;
            set_cnt   <= '0;
            end_set   <= '0;
        end else begin
            drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
            if (flush_ack) begin
                set_cnt <= start_set;
                end_set <= last_set;
            end else if (walk_inv && !walk_last) begin
                set_cnt <= set_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        flush_ack         = flush_req && state == IDLE;
        flush_busy        = state != IDLE;
        fetch_stall       = state != IDLE;
        flush_done        = state == DONE;
        itag_update_en    = walk_inv ? '1 : l2_itag_update_en;
        itag_update_set   = walk_inv ? set_cnt : l2_itag_update_set;
        itag_update_tag   = walk_inv ? '0 : l2_itag_update_tag;
        itag_update_valid = walk_inv ? 1'b0 : l2_itag_update_valid;
    end
endmodule

// File: tb/tb_icache_flush_sequencer.sv
// tb_icache_flush_sequencer: directed flush scenarios with a scoreboard of expected invalidates (set, cycle).
module tb_icache_flush_sequencer;
    import icache_flush_sequencer_pkg::*;

    typedef struct {int cyc; int sidx;} exp_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                flush_req;
    logic                flush_ack, flush_busy, flush_done, fetch_stall;
    logic [L1I_WAYS-1:0] l2_itag_update_en;
    l1i_set_idx_t        l2_itag_update_set;
    l1i_tag_t            l2_itag_update_tag;
    logic                l2_itag_update_valid;
    logic [L1I_WAYS-1:0] itag_update_en;
    l1i_set_idx_t        itag_update_set;
    l1i_tag_t            itag_update_tag;
    logic                itag_update_valid;
`ifdef ICACHE_FLUSH_RANGE_EN
    l1i_set_idx_t        flush_start_set;
    l1i_set_idx_t        flush_end_set;
`endif

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    icache_flush_sequencer #(.DRAIN_CYCLES(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush_req(flush_req),
`ifdef ICACHE_FLUSH_RANGE_EN
        .flush_start_set(flush_start_set),
        .flush_end_set(flush_end_set),
`endif
        .flush_ack(flush_ack),
        .flush_busy(flush_busy),
        .flush_done(flush_done),
        .fetch_stall(fetch_stall),
        .l2_itag_update_en(l2_itag_update_en),
        .l2_itag_update_set(l2_itag_update_set),
        .l2_itag_update_tag(l2_itag_update_tag),
        .l2_itag_update_valid(l2_itag_update_valid),
        .itag_update_en(itag_update_en),
        .itag_update_set(itag_update_set),
        .itag_update_tag(itag_update_tag),
        .itag_update_valid(itag_update_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic no_fill();
        l2_itag_update_en    = '0;
        l2_itag_update_set   = '0;
        l2_itag_update_tag   = '0;
        l2_itag_update_valid = 1'b0;
    endtask

    task automatic cyc_chk(input bit ack, input bit done, input bit busy);
        chk("ack", flush_ack, ack);
        chk("done", flush_done, done);
        chk("busy", flush_busy, busy);
        chk("stall", fetch_stall, busy);
    endtask

    // Every invalidate seen on the merged port must match the head of the scoreboard.
    task automatic mon(input int c);
        exp_t e;
        if (itag_update_en === '1 && itag_update_valid === 1'b0) begin
            chk("inv_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("inv_set", itag_update_set, e.sidx);
                chk("inv_cyc", c, e.cyc);
                chk("inv_tag", itag_update_tag, 0);
            end
        end
    endtask

    task automatic do_flush(input int first, input int last, input int fill_c, input int fill_set);
        int n, done_at, ic;
        n = (first > last ? first : last) - first + 1;
        done_at = 3 + n + (fill_c >= 0 ? 1 : 0);
        for (int s = 0; s < n; s++) begin
            ic = 3 + s;
            if (fill_c >= 0 && ic >= fill_c) ic++;
            q.push_back('{ic, first + s});
        end
        for (int c = 0; c <= done_at + 2; c++) begin
            flush_req = c == 0;
`ifdef ICACHE_FLUSH_RANGE_EN
            if (c == 0) begin
                flush_start_set = l1i_set_idx_t'(first);
                flush_end_set   = l1i_set_idx_t'(last);
            end
`endif
            if (c == fill_c) begin
                l2_itag_update_en    = 4'b0100;
                l2_itag_update_set   = l1i_set_idx_t'(fill_set);
                l2_itag_update_tag   = 20'hABCDE;
                l2_itag_update_valid = 1'b1;
            end else no_fill();
            @(negedge clk);
            cyc_chk(c == 0, c == done_at, c >= 1 && c <= done_at);
            if (c == fill_c) begin
                chk("fill_en", itag_update_en, 4'b0100);
                chk("fill_set", itag_update_set, fill_set);
                chk("fill_tag", itag_update_tag, 20'hABCDE);
                chk("fill_valid", itag_update_valid, 1);
            end
            mon(c);
            @(posedge clk);
            #1;
        end
        chk("q_empty", q.size(), 0);
        q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        flush_req = 1'b0;
        no_fill();
`ifdef ICACHE_FLUSH_RANGE_EN
        flush_start_set = '0;
        flush_end_set   = l1i_set_idx_t'(L1I_SETS - 1);
`endif
        #3;
        cyc_chk(0, 0, 0);
        chk("rst_en", itag_update_en, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Plain flush, then a fill colliding with the walker at set 10.
        do_flush(0, L1I_SETS - 1, -1, 0);
        do_flush(0, L1I_SETS - 1, 13, 10);

        // Request held high: re-acked in the first IDLE cycle after done.
        for (int c = 0; c <= 137; c++) begin
            flush_req = c <= 68;
            if (c == 0)  for (int s = 0; s < L1I_SETS; s++) q.push_back('{3 + s, s});
            if (c == 68) for (int s = 0; s < L1I_SETS; s++) q.push_back('{71 + s, s});
            @(negedge clk);
            cyc_chk(c == 0 || c == 68, c == 67 || c == 135,
                    (c >= 1 && c <= 67) || (c >= 69 && c <= 135));
            mon(c);
            @(posedge clk);
            #1;
        end
        flush_req = 1'b0;
        chk("held_q_empty", q.size(), 0);
        q.delete();

        // Abort mid-walk at counter 30.
        for (int s = 0; s < L1I_SETS; s++) q.push_back('{3 + s, s});
        for (int c = 0; c <= 33; c++) begin
            flush_req = c == 0;
            @(negedge clk);
            cyc_chk(c == 0, 0, c >= 1);
            mon(c);
            if (c != 33) begin
                @(posedge clk);
                #1;
            end
        end
        #1;
        reset_n = 1'b0;
        #1;
        cyc_chk(0, 0, 0);
        chk("abort_remaining", q.size(), L1I_SETS - 31);
        q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cyc_chk(0, 0, 0);
            mon(c);
            @(posedge clk);
            #1;
        end
        do_flush(0, L1I_SETS - 1, -1, 0);

        // Idle fill of set 63 bypasses straight through.
        l2_itag_update_en    = 4'b0001;
        l2_itag_update_set   = l1i_set_idx_t'(63);
        l2_itag_update_tag   = 20'h12345;
        l2_itag_update_valid = 1'b1;
        #1;
        chk("idle_en", itag_update_en, 4'b0001);
        chk("idle_set", itag_update_set, 63);
        chk("idle_tag", itag_update_tag, 20'h12345);
        chk("idle_valid", itag_update_valid, 1);
        chk("idle_stall", fetch_stall, 0);
        no_fill();
        @(posedge clk);
        #1;

`ifdef ICACHE_FLUSH_RANGE_EN
        do_flush(5, 7, -1, 0);
        do_flush(9, 3, -1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
